coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Snooping bus controller that sits between the two per-core dcaches and the shared RAM, on the memory side of `caches_if`. It arbitrates block reads, writebacks and write-hit invalidations from both caches round-robin. It issues snoops (`ccwait`/`ccinv`/`ccsnoopaddr`) to the non-requesting cache and services reads either cache-to-cache, with write-through to RAM, or from RAM.

## Interface
- Parameters:
  - `CPUS`, 2: number of dcache ports; only 2 is supported.
- Ports:
  - `CLK` in 1: clock, rising edge.
  - `RST` in 1: reset, asynchronous, active-high.
  - `dREN[CPUS]` in 1: block-word read request per cache.
  - `dWEN[CPUS]` in 1: writeback/flush word write per cache.
  - `daddr[CPUS]` in 32: word address from cache; in snoop reply, echo of snoop address.
  - `dstore[CPUS]` in 32: write data, or snoop reply data.
  - `cctrans[CPUS]` in 1: write-hit, requests invalidation of other copy.
  - `ccwrite[CPUS]` in 1: snoop hit reply.
  - `dwait[CPUS]` out 1: 0 = current word done this cycle.
  - `dload[CPUS]` out 32: read data.
  - `ccwait[CPUS]` out 1: snoop in progress, cache must freeze and answer.
  - `ccinv[CPUS]` out 1: invalidate snooped block.
  - `ccsnoopaddr[CPUS]` out 32: snoop word address.
  - `ramREN` out 1: RAM read.
  - `ramWEN` out 1: RAM write.
  - `ramaddr` out 32: RAM address.
  - `ramstore` out 32: RAM write data.
  - `ramload` in 32: RAM read data.
  - `ramstate` in `ramstate_t`: FREE/BUSY/ACCESS/ERROR; word completes when ACCESS.

## Operation
- Notation: `r` = granted requester; `o` = the other cache.
- Reset: state IDLE, round-robin pointer `rr`=0.
  - All outputs 0, except `dwait`=1 on both ports.
- Grant in IDLE: among caches asserting `dREN`, `dWEN` or `cctrans`, prefer `rr`, else the other.
  - `rr` flips to `o` when the grant returns to IDLE.
- Request type priority per cache: `dWEN` > `dREN` > `cctrans`.
- States:
  - IDLE:
    - `dWEN` -> WB1.
    - `dREN` -> SNOOP.
    - `cctrans` only -> INV.
  - WB1/WB2: `ramWEN`=1, `ramaddr`=`daddr[r]`, `ramstore`=`dstore[r]`.
    - On ACCESS: `dwait[r]`=0; WB1->WB2, WB2->IDLE.
    - No snoop.
  - INV: one cycle with `ccwait[o]`=1, `ccinv[o]`=1, `ccsnoopaddr[o]`=`daddr[r]`.
    - `dwait[r]` stays 1; -> IDLE.
  - SNOOP: one cycle with `ccwait[o]`=1, `ccsnoopaddr[o]`=`daddr[r]`, `ccinv[o]`=0.
    - `ccwrite[o]`=1 -> C2C1; else -> RAM1.
  - C2C1/C2C2: `ccwait[o]`=1, `ccsnoopaddr[o]`=`daddr[r]`.
    - `dload[r]`=`dstore[o]`; in parallel `ramWEN`=1, `ramaddr`=`daddr[r]`, `ramstore`=`dstore[o]` (write-through; snooper clears dirty).
    - On ACCESS: `dwait[r]`=0; C2C1->C2C2, C2C2->IDLE.
    - `ccinv[o]`=1 only in C2C2 (invalidating on word 0 would miss word 1), and only if `cctrans[r]`=1.
  - RAM1/RAM2: `ramREN`=1, `ramaddr`=`daddr[r]`, `dload[r]`=`ramload`.
    - On ACCESS: `dwait[r]`=0; RAM1->RAM2, RAM2->IDLE.
- `ccwait[r]` is never asserted. `ccwait` is never asserted to both caches at once.
- `ramstate`=ERROR: treated as BUSY (hold state).
- Requester dropping its request mid-transaction: ignored; the 2-word sequence completes.

## Timing
- `dwait`, `dload`, `cc*` and `ram*` outputs are combinational from state and inputs. State and `rr` are registered.
- Read miss latency, zero-wait RAM: SNOOP 1 cycle + 2 word cycles = 3 cycles.
- Writeback latency: 2 cycles. INV: 1 cycle.
- Simultaneous requests: one grant per IDLE visit.
  - The loser waits at most one full transaction (≤ 1 + 2·RAM latency + 1 cycles).
- `RST` mid-transaction: immediate return to IDLE, all outputs to reset values. No partial RAM write is retried.

## Structure
- `custom_types_pkg`:
  - `busstate_t`: IDLE, WB1, WB2, INV, SNOOP, C2C1, C2C2, RAM1, RAM2.
  - `ramstate_t` (if not already present).
- Sub-module `rr_arbiter`: 2-input round-robin grant with registered pointer and `done` pulse.

## Test plan
- Reset, no requests -> all `dwait`=1, `ccwait`=0, `ramREN`=`ramWEN`=0.
- Cache0 `dREN` `daddr`=0x100 then 0x104, cache1 `ccwrite`=0 -> SNOOP with `ccsnoopaddr[1]`=0x100, then RAM reads; cache0 gets `ramload` 0xAAAA, 0xBBBB with two `dwait[0]`=0 pulses.
- Cache1 read 0x200 (`cctrans[1]`=1), cache0 `ccwrite`=1 supplies 0x11, 0x22 -> `dload[1]`=0x11/0x22, RAM writes 0x200/0x204, `ccinv[0]`=1 only in C2C2.
- Both caches `dWEN` same cycle, `rr`=0 -> cache0 WB1/WB2 first, then cache1; `rr`=1 afterwards.
- Cache0 `cctrans` only, `daddr`=0x300 -> one cycle `ccwait[1]`=`ccinv[1]`=1, `ccsnoopaddr[1]`=0x300.
- `RST` pulsed during RAM2 with `ramstate`=BUSY -> next cycle IDLE, `ramREN`=0, `dwait`=1.

Source files
------------

// File: rtl/custom_types_pkg.sv
// Shared types for the coherence bus: RAM handshake state and bus controller FSM states.
package custom_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    WB1,
    WB2,
    INV,
    SNOOP,
    C2C1,
    C2C2,
    RAM1,
    RAM2
  } busstate_t;

  localparam int WORD_W = 32;

  // States that move one word through RAM and finish it on ACCESS.
  function automatic logic is_word_state(input busstate_t s);
    return s inside {WB1, WB2, C2C1, C2C2, RAM1, RAM2};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant; the pointer moves past the owner when its transaction is done.
module rr_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       done,
  output logic       gnt_valid,
  output logic       gnt_idx,
  output logic       owner
);

  logic rr_reg;
  logic owner_reg;

  assign gnt_valid = |req;
  assign gnt_idx   = req[rr_reg] ? rr_reg : ~rr_reg;
  assign owner     = owner_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_reg    <= 1'b0;
      owner_reg <= 1'b0;
    end else begin
      if (accept) owner_reg <= gnt_idx;
      if (done)   rr_reg    <= ~owner_reg;
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller between two dcaches and shared RAM: writebacks, invalidations,
// and block reads served cache-to-cache (with RAM write-through) or from RAM.
module coherence_bus_ctrl
  import custom_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [WORD_W-1:0]   daddr [CPUS],
  input  logic [WORD_W-1:0]   dstore [CPUS],
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     dwait,
  output logic [WORD_W-1:0]   dload [CPUS],
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [WORD_W-1:0]   ccsnoopaddr [CPUS],
  output logic                ramREN,
  output logic                ramWEN,
  output logic [WORD_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  input  logic [WORD_W-1:0]   ramload,
  input  ramstate_t           ramstate
);

  busstate_t state_reg;
  logic gnt_valid, gnt_idx, owner, other;
  logic accept, done, access, word_done;
  logic wb_phase, c2c_phase, ram_phase, snoop_phase;

  assign other     = ~owner;
  assign access    = (ramstate == ACCESS);
  assign accept    = (state_reg == IDLE) && gnt_valid;
  assign word_done = access && is_word_state(state_reg);
  assign done      = (state_reg == INV) ||
                     (word_done && (state_reg inside {WB2, C2C2, RAM2}));

  rr_arbiter u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req       (dREN | dWEN | cctrans),
    .accept    (accept),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .owner     (owner)
  );

  // ERROR and BUSY both leave the word pending, so only ACCESS advances.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:
          if (gnt_valid) begin
            if (dWEN[gnt_idx])      state_reg <= WB1;
            else if (dREN[gnt_idx]) state_reg <= SNOOP;
            else                    state_reg <= INV;
          end
        WB1:   if (access) state_reg <= WB2;
        WB2:   if (access) state_reg <= IDLE;
        INV:   state_reg <= IDLE;
        SNOOP: state_reg <= ccwrite[other] ? C2C1 : RAM1;
        C2C1:  if (access) state_reg <= C2C2;
        C2C2:  if (access) state_reg <= IDLE;
        RAM1:  if (access) state_reg <= RAM2;
        RAM2:  if (access) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wb_phase    = state_reg inside {WB1, WB2};
  assign c2c_phase   = state_reg inside {C2C1, C2C2};
  assign ram_phase   = state_reg inside {RAM1, RAM2};
  assign snoop_phase = state_reg inside {INV, SNOOP, C2C1, C2C2};

  assign ramWEN   = wb_phase | c2c_phase;
  assign ramREN   = ram_phase;
  assign ramaddr  = (wb_phase | c2c_phase | ram_phase) ? daddr[owner] : '0;
  assign ramstore = wb_phase  ? dstore[owner] :
                    c2c_phase ? dstore[other] : '0;

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_port
    localparam logic IDX = (gi != 0);
    logic is_r;
    assign is_r = (owner == IDX);

    assign dwait[gi]       = ~(is_r & word_done);
    assign dload[gi]       = ~is_r     ? '0 :
                             c2c_phase ? dstore[other] :
                             ram_phase ? ramload : '0;
    assign ccwait[gi]      = ~is_r & snoop_phase;
    // Invalidating on the first word would leave the second word unserved.
    assign ccinv[gi]       = ~is_r & ((state_reg == INV) |
                                      ((state_reg == C2C2) & cctrans[owner]));
    assign ccsnoopaddr[gi] = (~is_r & snoop_phase) ? daddr[owner] : '0;
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Randomized scoreboard bench: expected snoop and word events are queued per transaction
// and matched by an independent monitor watching ccwait changes and dwait pulses.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;
  import custom_types_pkg::*;

  localparam int CPUS = 2;
  localparam int K_WB = 0, K_RD = 1, K_INV = 2;

  logic CLK = 1'b0;
  logic RST;
  logic [CPUS-1:0] dREN, dWEN, cctrans, ccwrite, dwait, ccwait, ccinv;
  logic [31:0] daddr [CPUS];
  logic [31:0] dstore [CPUS];
  logic [31:0] dload [CPUS];
  logic [31:0] ccsnoopaddr [CPUS];
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(CPUS)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    bit          snoop;
    bit          port;
    bit          inv;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    bit          chk_store;
    logic [31:0] store;
    bit          chk_load;
    logic [31:0] load;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  // Per-group cache configuration.
  bit          act [2];
  int          kind [2];
  logic [31:0] base [2];
  logic [31:0] wbd [2][2];
  bit          hit [2];
  bit          ct [2];
  logic [31:0] salt;
  bit          rr_m;

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hAAAA, ~a[15:0]};
  endfunction

  function automatic logic [31:0] snp_fn(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'd7) ^ s;
  endfunction

  assign ramload = ram_fn(ramaddr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push_word(input bit p, input bit rd, input bit wr, input logic [31:0] a,
                           input bit cs, input logic [31:0] st, input bit cl, input logic [31:0] ld);
    ev_t e;
    e = '{snoop:1'b0, port:p, inv:1'b0, addr:a, rd:rd, wr:wr,
          chk_store:cs, store:st, chk_load:cl, load:ld};
    exp_q.push_back(e);
  endtask

  task automatic push_snoop(input bit p, input bit inv, input logic [31:0] a);
    ev_t e;
    e = '{snoop:1'b1, port:p, inv:inv, addr:a, rd:1'b0, wr:1'b0,
          chk_store:1'b0, store:'0, chk_load:1'b0, load:'0};
    exp_q.push_back(e);
  endtask

  // Expected bus activity of one granted transaction, from the protocol rules.
  task automatic push_txn(input bit g);
    bit o;
    logic [31:0] a;
    o = ~g;
    if (kind[g] == K_WB) begin
      for (int k = 0; k < 2; k++)
        push_word(g, 1'b0, 1'b1, base[g] + 4*k, 1'b1, wbd[g][k], 1'b0, '0);
    end else if (kind[g] == K_INV) begin
      push_snoop(o, 1'b1, base[g]);
    end else begin
      push_snoop(o, 1'b0, base[g]);
      if (hit[o]) begin
        a = base[g];
        push_word(g, 1'b0, 1'b1, a, 1'b1, snp_fn(a, salt), 1'b1, snp_fn(a, salt));
        a = base[g] + 4;
        push_snoop(o, ct[g], a);
        push_word(g, 1'b0, 1'b1, a, 1'b1, snp_fn(a, salt), 1'b1, snp_fn(a, salt));
      end else begin
        for (int k = 0; k < 2; k++)
          push_word(g, 1'b1, 1'b0, base[g] + 4*k, 1'b0, '0, 1'b1, ram_fn(base[g] + 4*k));
      end
    end
    rr_m = o;
  endtask

  // Monitor: one comparison line per observed event.
  bit [1:0]    prev_ccw = '0;
  bit [1:0]    prev_inv = '0;
  logic [31:0] prev_sa [2];

  task automatic take(input bit is_snoop, input bit p);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: port %0d got event, expected none", is_snoop ? "snoop" : "word", p);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", is_snoop, e.snoop);
    chk("event_port", p, e.port);
    if (is_snoop) begin
      chk("ccinv", ccinv[p], e.inv);
      chk("ccsnoopaddr", ccsnoopaddr[p], e.addr);
      $display("snoop  port=%0d addr=%h inv=%0d", p, ccsnoopaddr[p], ccinv[p]);
    end else begin
      chk("ramREN", ramREN, e.rd);
      chk("ramWEN", ramWEN, e.wr);
      chk("ramaddr", ramaddr, e.addr);
      if (e.chk_store) chk("ramstore", ramstore, e.store);
      if (e.chk_load)  chk("dload", dload[p], e.load);
      $display("word   port=%0d addr=%h REN=%0d WEN=%0d load=%h store=%h",
               p, ramaddr, ramREN, ramWEN, dload[p], ramstore);
    end
  endtask

  initial begin
    prev_sa[0] = '0;
    prev_sa[1] = '0;
    forever begin
      @(negedge CLK);
      chk("ccwait_exclusive", ccwait[0] & ccwait[1], 1'b0);
      for (int j = 0; j < 2; j++)
        if (ccwait[j] && (!prev_ccw[j] || prev_sa[j] !== ccsnoopaddr[j] || prev_inv[j] !== ccinv[j]))
          take(1'b1, j[0]);
      for (int j = 0; j < 2; j++) begin
        prev_ccw[j] = ccwait[j];
        prev_inv[j] = ccinv[j];
        prev_sa[j]  = ccsnoopaddr[j];
      end
      for (int i = 0; i < 2; i++)
        if (!dwait[i]) take(1'b0, i[0]);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dwait"}, dwait, 2'b11);
    chk({tag, "_ccwait"}, ccwait, 2'b00);
    chk({tag, "_ccinv"}, ccinv, 2'b00);
    chk({tag, "_ramREN"}, ramREN, 1'b0);
    chk({tag, "_ramWEN"}, ramWEN, 1'b0);
    chk({tag, "_ramaddr"}, ramaddr, 32'h0);
    chk({tag, "_dload0"}, dload[0], 32'h0);
  endtask

  task automatic drop_requests();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
  endtask

  // Drives the configured caches until every active one has finished.
  task automatic run_group(input bit stall);
    int widx [2];
    bit done [2];
    int cyc;
    bit o;
    bit both;
    widx[0] = 0; widx[1] = 0;
    done[0] = !act[0]; done[1] = !act[1];
    both = act[0] && act[1];
    if (both) begin
      push_txn(rr_m);
      push_txn(rr_m);
    end else begin
      push_txn(act[1]);
    end
    cyc = 0;
    while (!(done[0] && done[1])) begin
      @(posedge CLK); #1;
      for (int c = 0; c < 2; c++) begin
        dWEN[c]    = act[c] && !done[c] && kind[c] == K_WB;
        dREN[c]    = act[c] && !done[c] && kind[c] == K_RD;
        cctrans[c] = act[c] && !done[c] && (kind[c] == K_INV || (kind[c] == K_RD && ct[c]));
        daddr[c]   = base[c] + 4 * widx[c];
      end
      if (stall && (widx[0] == 1 || widx[1] == 1))
        ramstate = BUSY;
      else
        case ($urandom % 6)
          0: ramstate = BUSY;
          1: ramstate = ERROR;
          default: ramstate = ACCESS;
        endcase
      #1;
      for (int c = 0; c < 2; c++) begin
        if (ccwait[c]) begin
          dstore[c]  = snp_fn(ccsnoopaddr[c], salt);
          ccwrite[c] = hit[c];
        end else begin
          dstore[c]  = (kind[c] == K_WB) ? wbd[c][widx[c] > 0 ? 1 : 0] : 32'h0;
          ccwrite[c] = 1'b0;
        end
      end
      @(negedge CLK);
      if (stall && widx[0] == 1 && ramREN) begin
        #1;
        RST = 1'b1;
        drop_requests();
        #1;
        chk_reset_outputs("midreset");
        rr_m = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("flushed_word", exp_q.size(), 1);
        exp_q.delete();
        return;
      end
      for (int c = 0; c < 2; c++) begin
        o = ~c[0];
        if (act[c] && !done[c]) begin
          if (kind[c] == K_INV) begin
            if (ccwait[o] && ccinv[o] && ccsnoopaddr[o] == base[c]) done[c] = 1'b1;
          end else if (!dwait[c]) begin
            widx[c]++;
            if (widx[c] == 2) done[c] = 1'b1;
          end
        end
      end
      cyc++;
      if (cyc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL group_timeout: got %0d cycles, expected at most 200", cyc);
        break;
      end
    end
    @(posedge CLK); #1;
    drop_requests();
    ramstate = ACCESS;
    repeat (2) @(posedge CLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b1;
    drop_requests();
    ramstate = FREE;
    salt = 32'h0;
    rr_m = 1'b0;
    for (int c = 0; c < 2; c++) begin
      daddr[c] = '0; dstore[c] = '0; act[c] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #2;
    chk_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk_reset_outputs("idle");

    for (int t = 0; t < 80; t++) begin
      int mode;
      mode = $urandom % 3;
      act[0] = (mode != 1);
      act[1] = (mode != 0);
      salt = $urandom;
      for (int c = 0; c < 2; c++) begin
        kind[c]   = $urandom % 3;
        base[c]   = (kind[c] == K_INV) ? 32'h8000 + ($urandom % 256) * 8 : ($urandom % 512) * 8;
        wbd[c][0] = $urandom;
        wbd[c][1] = $urandom;
        hit[c]    = $urandom % 2;
        ct[c]     = $urandom % 2;
      end
      run_group(1'b0);
    end

    // Read miss interrupted by reset while its second word is stalled.
    act[0] = 1'b1; act[1] = 1'b0;
    kind[0] = K_RD; base[0] = 32'h100; ct[0] = 1'b0; hit[1] = 1'b0;
    run_group(1'b1);
    repeat (2) @(posedge CLK);
    #2;
    chk_reset_outputs("after_midreset");

    // The pointer is back at 0 after reset, so cache0 must win a tie.
    act[0] = 1'b1; act[1] = 1'b1;
    kind[0] = K_WB; kind[1] = K_WB;
    base[0] = 32'h400; base[1] = 32'h500;
    wbd[0][0] = 32'h1111; wbd[0][1] = 32'h2222; wbd[1][0] = 32'h3333; wbd[1][1] = 32'h4444;
    run_group(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
